// File: rtl/audio_gain_stage.sv
// ============================================================================
// audio_gain_stage
// ----------------------------------------------------------------------------
// Multi-channel volume stage that sits between the audio codec read and write
// paths. Every accepted frame is scaled by a signed, saturating gain. The
// applied gain moves toward a target by at most RAMP_STEP per accepted frame,
// which avoids audible zipper noise when the volume changes. A single
// multiplier is shared by all channels, one channel per cycle.
//
// Optional feature macro:
//   AUD_GAIN_SOFTMUTE_EN - adds the 'mute' input. While mute is high the
//                          effective target is zero. Target writes made
//                          during mute are kept and used on release.
//
// Parameters:
//   DATA_W     signed sample width per channel
//   CH         channels per frame (channel 0 in the LSBs)
//   GAIN_W     unsigned gain width, fixed point Q2.(GAIN_W-2)
//   RAMP_STEP  max change of the applied gain per accepted frame (>= 1)
//
// Ports:
//   CLOCK_50    system clock, all logic on the rising edge
//   reset       asynchronous active-high reset
//   in_valid    input frame valid
//   in_ready    stage can accept a frame (high only while idle)
//   in_data     packed input samples, CH*DATA_W bits
//   out_valid   output frame valid (high only while presenting a frame)
//   out_ready   sink accepts the presented frame
//   out_data    packed scaled samples, registered
//   gain_valid  one-cycle strobe that latches gain_in as the new target
//   gain_in     new target gain
//   gain_cur    gain currently applied (status)
//   mute        soft-mute request (only with AUD_GAIN_SOFTMUTE_EN)
// ============================================================================
module audio_gain_stage #(
    parameter int DATA_W    = 24,
    parameter int CH        = 2,
    parameter int GAIN_W    = 8,
    parameter int RAMP_STEP = 4
) (
    input  logic                   CLOCK_50,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [CH*DATA_W-1:0]   in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CH*DATA_W-1:0]   out_data,
    input  logic                   gain_valid,
    input  logic [GAIN_W-1:0]      gain_in,
    output logic [GAIN_W-1:0]      gain_cur
`ifdef AUD_GAIN_SOFTMUTE_EN
    ,
    input  logic                   mute
`endif
);

    // Product width: signed sample times a gain with a forced-zero sign bit.
    localparam int P_W  = DATA_W + GAIN_W + 1;
    localparam int CH_W = (CH > 1) ? $clog2(CH) : 1;

    localparam logic [GAIN_W-1:0] UNITY = GAIN_W'(2 ** (GAIN_W - 2));
    localparam logic [GAIN_W-1:0] STEP_U = GAIN_W'(RAMP_STEP);
    localparam logic signed [GAIN_W+1:0] STEP_S = (GAIN_W + 2)'(RAMP_STEP);
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(CH - 1);

    // Clip limits expressed at product width so the compare is a plain
    // signed comparison against the shifted product.
    localparam logic signed [P_W-1:0] SAT_MAX =
        {{(P_W - DATA_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}};
    localparam logic signed [P_W-1:0] SAT_MIN =
        {{(P_W - DATA_W + 1){1'b1}}, {(DATA_W - 1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [CH*DATA_W-1:0]   inData_q, inData_d;
    logic [CH*DATA_W-1:0]   outData_q, outData_d;
    logic [CH_W-1:0]        chIdx_q, chIdx_d;
    logic [GAIN_W-1:0]      gainCur_q, gainCur_d;
    logic [GAIN_W-1:0]      target_q, target_d;

    logic                   accept;
    logic                   lastCh;
    logic [GAIN_W-1:0]      effTarget;
    logic signed [GAIN_W+1:0] gainDiff;
    logic [GAIN_W-1:0]      gainStep;

    int                     chBase;
    logic [DATA_W-1:0]      sample;
    logic signed [P_W-1:0]  sampleExt;
    logic signed [P_W-1:0]  gainExt;
    logic signed [P_W-1:0]  prod;
    logic signed [P_W-1:0]  shifted;
    logic [DATA_W-1:0]      satSample;

    // ------------------------------------------------------------------
    // FSM state register.
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state: accept -> one MUL cycle per channel -> hold the
    // result in OUT until the sink takes it.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = MUL;
                end
            end
            MUL: begin
                if (lastCh) begin
                    state_d = OUT;
                end
            end
            OUT: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM outputs, decoded purely from the current state.
    // ------------------------------------------------------------------
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == OUT);
    end

    assign accept = in_valid && (state_q == IDLE);
    assign lastCh = (chIdx_q == LAST_CH);

    // ------------------------------------------------------------------
    // Effective target: mute forces a ramp toward zero without losing the
    // stored target, so release ramps back to whatever was last written.
    // ------------------------------------------------------------------
`ifdef AUD_GAIN_SOFTMUTE_EN
    assign effTarget = mute ? '0 : target_q;
`else
    assign effTarget = target_q;
`endif

    // ------------------------------------------------------------------
    // Ramp limiter. The difference is taken two bits wider than the gain
    // so both directions are representable without wrap.
    // ------------------------------------------------------------------
    always_comb begin
        gainDiff = $signed({2'b00, effTarget}) - $signed({2'b00, gainCur_q});
        if (gainDiff > STEP_S) begin
            gainStep = gainCur_q + STEP_U;
        end else if (gainDiff < -STEP_S) begin
            gainStep = gainCur_q - STEP_U;
        end else begin
            gainStep = effTarget;
        end
    end

    // ------------------------------------------------------------------
    // Shared multiplier. The gain gets a zero sign bit so that gains with
    // the MSB set are still treated as positive. The arithmetic shift
    // floors toward minus infinity, then the result is clipped to the
    // sample range.
    // ------------------------------------------------------------------
    always_comb begin
        chBase    = int'(chIdx_q) * DATA_W;
        sample    = inData_q[chBase +: DATA_W];
        sampleExt = {{(P_W - DATA_W){sample[DATA_W-1]}}, sample};
        gainExt   = {{(P_W - GAIN_W){1'b0}}, gainCur_q};
        prod      = sampleExt * gainExt;
        shifted   = prod >>> (GAIN_W - 2);
        if (shifted > SAT_MAX) begin
            satSample = {1'b0, {(DATA_W - 1){1'b1}}};
        end else if (shifted < SAT_MIN) begin
            satSample = {1'b1, {(DATA_W - 1){1'b0}}};
        end else begin
            satSample = shifted[DATA_W-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Datapath next state. The gain steps at the moment of accept, so the
    // frame just taken is already scaled by the updated gain.
    // ------------------------------------------------------------------
    always_comb begin
        inData_d  = inData_q;
        outData_d = outData_q;
        chIdx_d   = chIdx_q;
        gainCur_d = gainCur_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    inData_d  = in_data;
                    gainCur_d = gainStep;
                    chIdx_d   = '0;
                end
            end
            MUL: begin
                outData_d[chBase +: DATA_W] = satSample;
                chIdx_d = lastCh ? '0 : chIdx_q + CH_W'(1);
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Target register. A write coincident with an accept is seen by the
    // ramp only from the next frame because the step reads target_q.
    // ------------------------------------------------------------------
    always_comb begin
        target_d = gain_valid ? gain_in : target_q;
    end

    // ------------------------------------------------------------------
    // Datapath registers. Reset discards any frame in flight.
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            inData_q  <= '0;
            outData_q <= '0;
            chIdx_q   <= '0;
            gainCur_q <= UNITY;
            target_q  <= UNITY;
        end else begin
            inData_q  <= inData_d;
            outData_q <= outData_d;
            chIdx_q   <= chIdx_d;
            gainCur_q <= gainCur_d;
            target_q  <= target_d;
        end
    end

    assign out_data = outData_q;
    assign gain_cur = gainCur_q;

endmodule

// File: tb/tb_audio_gain_stage.sv
// ============================================================================
// tb_audio_gain_stage
// ----------------------------------------------------------------------------
// Directed plus randomized frames for audio_gain_stage. The expected samples
// come from a reference model using plain integer arithmetic: floor division
// by the unity gain and clamping to the sample range. The applied gain is
// tracked with a simple "move toward target by at most RAMP_STEP" rule.
// ============================================================================
module tb_audio_gain_stage;

    localparam int DATA_W    = 24;
    localparam int CH        = 2;
    localparam int GAIN_W    = 8;
    localparam int RAMP_STEP = 4;
    localparam int UNITY     = 64;

    logic                 CLOCK_50;
    logic                 reset;
    logic                 in_valid;
    logic                 in_ready;
    logic [CH*DATA_W-1:0] in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [CH*DATA_W-1:0] out_data;
    logic                 gain_valid;
    logic [GAIN_W-1:0]    gain_in;
    logic [GAIN_W-1:0]    gain_cur;
`ifdef AUD_GAIN_SOFTMUTE_EN
    logic                 mute;
    bit                   muteModel;
`endif

    int total;
    int bad;
    int gModel;
    int tModel;

    audio_gain_stage #(
        .DATA_W    (DATA_W),
        .CH        (CH),
        .GAIN_W    (GAIN_W),
        .RAMP_STEP (RAMP_STEP)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .gain_valid (gain_valid),
        .gain_in    (gain_in),
        .gain_cur   (gain_cur)
`ifdef AUD_GAIN_SOFTMUTE_EN
        ,
        .mute       (mute)
`endif
    );

    // Free-running 100 MHz-style clock.
    initial begin
        CLOCK_50 = 1'b0;
        forever #5 CLOCK_50 = ~CLOCK_50;
    end

    // One comparison: count it, and report it when it does not hold.
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference scaling: floor(sample * gain / unity), clamped.
    function automatic logic [DATA_W-1:0] scale(input logic [DATA_W-1:0] s, input int g);
        longint sv;
        longint p;
        longint q;
        longint hi;
        longint lo;
        sv = longint'($signed(s));
        p  = sv * longint'(g);
        q  = p / longint'(UNITY);
        if (p < 0 && (p % longint'(UNITY)) != 0) q = q - 1;
        hi = (longint'(1) <<< (DATA_W - 1)) - 1;
        lo = -(longint'(1) <<< (DATA_W - 1));
        if (q > hi) q = hi;
        if (q < lo) q = lo;
        return q[DATA_W-1:0];
    endfunction

    // Reference ramp: move toward the effective target by at most RAMP_STEP.
    function automatic int nextGain(input int g, input int t);
        int d;
        d = t - g;
        if (d > RAMP_STEP) return g + RAMP_STEP;
        if (d < -RAMP_STEP) return g - RAMP_STEP;
        return t;
    endfunction

    function automatic int effTargetModel();
`ifdef AUD_GAIN_SOFTMUTE_EN
        if (muteModel) return 0;
`endif
        return tModel;
    endfunction

    task automatic setGain(input int g);
        gain_valid = 1'b1;
        gain_in    = GAIN_W'(g);
        @(posedge CLOCK_50); #1;
        gain_valid = 1'b0;
        tModel     = g;
    endtask

    // Send one frame with out_ready high and check latency, samples, gain
    // and the return to idle.
    task automatic applyStimulus(input logic [DATA_W-1:0] s0, input logic [DATA_W-1:0] s1,
                                 input bit coGain, input int newG);
        int cnt;
        logic [CH*DATA_W-1:0] expData;
        cnt = 0;
        while (in_ready !== 1'b1 && cnt < 50) begin
            @(posedge CLOCK_50); #1;
            cnt++;
        end
        checkOutput("ready_before_accept", 64'(in_ready), 64'(1));
        in_valid = 1'b1;
        in_data  = {s1, s0};
        if (coGain) begin
            gain_valid = 1'b1;
            gain_in    = GAIN_W'(newG);
        end
        @(posedge CLOCK_50); #1;
        in_valid   = 1'b0;
        gain_valid = 1'b0;
        gModel = nextGain(gModel, effTargetModel());
        if (coGain) tModel = newG;
        expData = {scale(s1, gModel), scale(s0, gModel)};
        cnt = 0;
        while (out_valid !== 1'b1 && cnt < 20) begin
            @(posedge CLOCK_50); #1;
            cnt++;
        end
        checkOutput("latency", 64'(cnt), 64'(CH));
        checkOutput("out_data", 64'(out_data), 64'(expData));
        checkOutput("gain_cur", 64'(gain_cur), 64'(gModel));
        @(posedge CLOCK_50); #1;
        checkOutput("idle_after_out", 64'({out_valid, in_ready}), 64'(2'b01));
    endtask

    initial begin
        logic [DATA_W-1:0] r0;
        logic [DATA_W-1:0] r1;
        logic [CH*DATA_W-1:0] expBp;
        int cnt;
        int sel;

        total      = 0;
        bad        = 0;
        gModel     = UNITY;
        tModel     = UNITY;
        reset      = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b1;
        gain_valid = 1'b0;
        gain_in    = '0;
`ifdef AUD_GAIN_SOFTMUTE_EN
        mute      = 1'b0;
        muteModel = 1'b0;
`endif
        repeat (3) @(posedge CLOCK_50);
        #1;
        checkOutput("reset_in_ready", 64'(in_ready), 64'(1));
        checkOutput("reset_out_valid", 64'(out_valid), 64'(0));
        checkOutput("reset_out_data", 64'(out_data), 64'(0));
        checkOutput("reset_gain_cur", 64'(gain_cur), 64'(UNITY));
        reset = 1'b0;
        @(posedge CLOCK_50); #1;

        // Unity passthrough.
        applyStimulus(24'h123456, 24'hFEDCBA, 1'b0, 0);
        checkOutput("unity_passthrough", 64'(out_data), 64'(48'hFEDCBA_123456));
        for (int i = 0; i < 4; i++) begin
            applyStimulus(DATA_W'($urandom()), DATA_W'($urandom()), 1'b0, 0);
        end

        // Ramp from unity toward 128 in steps of RAMP_STEP.
        setGain(128);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(DATA_W'($urandom()), DATA_W'($urandom()), 1'b0, 0);
            checkOutput("ramp_up_gain", 64'(gain_cur), 64'(UNITY + RAMP_STEP * (i + 1)));
        end
        applyStimulus(DATA_W'($urandom()), DATA_W'($urandom()), 1'b0, 0);
        checkOutput("ramp_stable", 64'(gain_cur), 64'(128));

        // Saturation boundaries at gain 2.0.
        applyStimulus(24'h400000, 24'hC00000, 1'b0, 0);
        checkOutput("sat_edges", 64'(out_data), 64'(48'h800000_7FFFFF));
        applyStimulus(24'h000001, 24'hFFFFFF, 1'b0, 0);
        checkOutput("small_values", 64'(out_data), 64'(48'hFFFFFE_000002));

        // Difference within one step lands exactly on the target.
        setGain(130);
        applyStimulus(DATA_W'($urandom()), DATA_W'($urandom()), 1'b0, 0);
        checkOutput("exact_target", 64'(gain_cur), 64'(130));

        // Random targets, some written in the same cycle as an accept.
        for (int i = 0; i < 40; i++) begin
            sel = int'($urandom_range(0, 3));
            if (sel == 0) setGain(int'($urandom_range(0, 255)));
            applyStimulus(DATA_W'($urandom()), DATA_W'($urandom()),
                          (sel == 1), int'($urandom_range(0, 255)));
        end

        // Gain zero: ramp all the way down, output goes silent.
        setGain(0);
        for (int i = 0; i < 70; i++) begin
            applyStimulus(DATA_W'($urandom()), DATA_W'($urandom()), 1'b0, 0);
        end
        checkOutput("zero_gain", 64'(gain_cur), 64'(0));
        checkOutput("zero_out", 64'(out_data), 64'(0));

        // Maximum gain with large samples exercises clipping.
        setGain(255);
        for (int i = 0; i < 70; i++) begin
            applyStimulus(DATA_W'($urandom()), DATA_W'($urandom()), 1'b0, 0);
        end
        checkOutput("max_gain", 64'(gain_cur), 64'(255));

        // Backpressure: the frame is held and no second frame is taken even
        // though in_valid stays high. A new target makes a spurious accept
        // visible as an extra gain step.
        setGain(20);
        out_ready = 1'b0;
        r0 = DATA_W'($urandom());
        r1 = DATA_W'($urandom());
        in_valid = 1'b1;
        in_data  = {r1, r0};
        @(posedge CLOCK_50); #1;
        gModel = nextGain(gModel, effTargetModel());
        expBp  = {scale(r1, gModel), scale(r0, gModel)};
        in_data = {DATA_W'($urandom()), DATA_W'($urandom())};
        cnt = 0;
        while (out_valid !== 1'b1 && cnt < 20) begin
            @(posedge CLOCK_50); #1;
            cnt++;
        end
        checkOutput("bp_latency", 64'(cnt), 64'(CH));
        for (int i = 0; i < 50; i++) begin
            checkOutput("bp_out_valid", 64'(out_valid), 64'(1));
            checkOutput("bp_out_data", 64'(out_data), 64'(expBp));
            checkOutput("bp_in_ready", 64'(in_ready), 64'(0));
            @(posedge CLOCK_50); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge CLOCK_50); #1;
        checkOutput("bp_release", 64'({out_valid, in_ready}), 64'(2'b01));
        checkOutput("bp_no_extra_accept", 64'(gain_cur), 64'(gModel));
        applyStimulus(DATA_W'($urandom()), DATA_W'($urandom()), 1'b0, 0);

        // Reset in the middle of MUL discards the frame immediately.
        in_valid = 1'b1;
        in_data  = {DATA_W'($urandom()), DATA_W'($urandom())};
        @(posedge CLOCK_50); #1;
        in_valid = 1'b0;
        reset    = 1'b1;
        #1;
        checkOutput("midreset_out_valid", 64'(out_valid), 64'(0));
        checkOutput("midreset_in_ready", 64'(in_ready), 64'(1));
        checkOutput("midreset_gain_cur", 64'(gain_cur), 64'(UNITY));
        checkOutput("midreset_out_data", 64'(out_data), 64'(0));
        @(posedge CLOCK_50); #1;
        reset  = 1'b0;
        gModel = UNITY;
        tModel = UNITY;
        @(posedge CLOCK_50); #1;
        applyStimulus(24'h123456, 24'hFEDCBA, 1'b0, 0);
        checkOutput("post_reset_frame", 64'(out_data), 64'(48'hFEDCBA_123456));

`ifdef AUD_GAIN_SOFTMUTE_EN
        // Soft mute ramps to silence, a write during mute is applied on
        // release.
        mute      = 1'b1;
        muteModel = 1'b1;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(DATA_W'($urandom()), DATA_W'($urandom()), 1'b0, 0);
            checkOutput("mute_ramp", 64'(gain_cur), 64'(UNITY - RAMP_STEP * (i + 1)));
        end
        checkOutput("mute_out_zero", 64'(out_data), 64'(0));
        setGain(100);
        applyStimulus(DATA_W'($urandom()), DATA_W'($urandom()), 1'b0, 0);
        checkOutput("mute_hold", 64'(gain_cur), 64'(0));
        mute      = 1'b0;
        muteModel = 1'b0;
        for (int i = 0; i < 25; i++) begin
            applyStimulus(DATA_W'($urandom()), DATA_W'($urandom()), 1'b0, 0);
        end
        checkOutput("unmute_target", 64'(gain_cur), 64'(100));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
